// File: rtl/players_pkg.sv
// Types and constants shared by the player sprite controllers (dog and cat).
package players_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WIND     = 2'd1,
        ST_RELEASE  = 2'd2,
        ST_COOLDOWN = 2'd3
    } anim_state_e;

    typedef logic [1:0] frame_sel_t;

    localparam frame_sel_t FRAME_IDLE    = 2'b00;
    localparam frame_sel_t FRAME_WIND    = 2'b01;
    localparam frame_sel_t FRAME_RELEASE = 2'b10;

    localparam int DOG_W = 140;
    localparam int DOG_H = 177;

    // COOLDOWN shows the idle image.
    function automatic frame_sel_t frame_sel_of(input anim_state_e st);
        case (st)
            ST_WIND:    return FRAME_WIND;
            ST_RELEASE: return FRAME_RELEASE;
            default:    return FRAME_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Maps VGA counters to a sprite-relative ROM address, with an in-sprite flag
// delayed to line up with the ROM's registered output.
module sprite_addr_gen #(
    parameter int SPRITE_W = 140,
    parameter int SPRITE_H = 177
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [10:0] hcount_i,
    input  logic [10:0] vcount_i,
    input  logic [10:0] xpos_i,
    input  logic [10:0] ypos_i,
    output logic [14:0] address_o,
    output logic        in_sprite_o
);

    logic [11:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end;
    logic [10:0] dx, dy;
    logic        in_win;
    logic [14:0] addr_d, addr_q;
    logic        win_q, in_sprite_q;

    // 12-bit bounds so a sprite near the 2047 edge does not wrap.
    always_comb begin
        h_ext  = {1'b0, hcount_i};
        v_ext  = {1'b0, vcount_i};
        x_ext  = {1'b0, xpos_i};
        y_ext  = {1'b0, ypos_i};
        x_end  = x_ext + 12'(SPRITE_W);
        y_end  = y_ext + 12'(SPRITE_H);
        in_win = (h_ext >= x_ext) && (h_ext < x_end) &&
                 (v_ext >= y_ext) && (v_ext < y_end);
        dx     = hcount_i - xpos_i;
        dy     = vcount_i - ypos_i;
        addr_d = '0;
        if (in_win)
            addr_d = 15'(dy) * 15'(SPRITE_W) + 15'(dx);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            win_q       <= 1'b0;
            in_sprite_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            win_q       <= in_win;
            in_sprite_q <= win_q;
        end
    end

    assign address_o   = addr_q;
    assign in_sprite_o = in_sprite_q;

endmodule

// File: rtl/dog_anim_ctrl.sv
// Dog throw animation sequencer plus dog sprite ROM address generation.
module dog_anim_ctrl
    import players_pkg::*;
#(
    parameter int SPRITE_W        = DOG_W,
    parameter int SPRITE_H        = DOG_H,
    parameter int WIND_FRAMES     = 8,
    parameter int RELEASE_FRAMES  = 6,
    parameter int COOLDOWN_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        throw_req,
    output logic        throw_ack,
    output logic        launch,
    output logic        busy,
    output logic [1:0]  frame_sel,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic [14:0] address,
    output logic        in_sprite
);

    localparam logic [5:0] WIND_LAST = 6'(WIND_FRAMES - 1);
    localparam logic [5:0] REL_LAST  = 6'(RELEASE_FRAMES - 1);
    localparam logic [5:0] COOL_LAST = 6'(COOLDOWN_FRAMES - 1);

    anim_state_e state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ack_d, ack_q, launch_d, launch_q, busy_q;
    frame_sel_t  frame_sel_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        launch_d = 1'b0;
        if (frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (throw_req) begin
                        state_d = ST_WIND;
                        cnt_d   = '0;
                        ack_d   = 1'b1;
                    end
                end
                ST_WIND: begin
                    if (cnt_q == WIND_LAST) begin
                        state_d  = ST_RELEASE;
                        cnt_d    = '0;
                        launch_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == REL_LAST) begin
                        state_d = (COOLDOWN_FRAMES > 0) ? ST_COOLDOWN : ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_COOLDOWN: begin
                    if (cnt_q == COOL_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change the cycle after the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            frame_sel_q <= FRAME_IDLE;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            launch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_sel_q <= frame_sel_of(state_d);
            busy_q      <= (state_d != ST_IDLE);
            ack_q       <= ack_d;
            launch_q    <= launch_d;
        end
    end

    assign frame_sel = frame_sel_q;
    assign busy      = busy_q;
    assign throw_ack = ack_q;
    assign launch    = launch_q;

    sprite_addr_gen #(
        .SPRITE_W(SPRITE_W),
        .SPRITE_H(SPRITE_H)
    ) u_addr (
        .clk_i      (clk),
        .rst_i      (rst),
        .hcount_i   (hcount),
        .vcount_i   (vcount),
        .xpos_i     (xpos),
        .ypos_i     (ypos),
        .address_o  (address),
        .in_sprite_o(in_sprite)
    );

endmodule

// File: tb/tb_dog_anim_ctrl.sv
// Directed scoreboard bench for dog_anim_ctrl: throw sequencing and sprite addressing.
module tb_dog_anim_ctrl;

    logic        clk = 1'b0;
    logic        rst, frame_tick, throw_req;
    logic        throw_ack, launch, busy, in_sprite;
    logic [1:0]  frame_sel;
    logic [10:0] hcount, vcount, xpos, ypos;
    logic [14:0] address;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string      tag;
        logic [1:0] sel;
        logic       busy, ack, launch;
    } fsm_exp_t;

    typedef struct {
        string       tag;
        logic [14:0] addr;
        logic        ins;
    } adr_exp_t;

    fsm_exp_t fq[$];
    adr_exp_t aq[$];
    adr_exp_t iq[$];

    dog_anim_ctrl #(
        .SPRITE_W(140), .SPRITE_H(177),
        .WIND_FRAMES(8), .RELEASE_FRAMES(6), .COOLDOWN_FRAMES(10)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .throw_req(throw_req),
        .throw_ack(throw_ack), .launch(launch), .busy(busy), .frame_sel(frame_sel),
        .hcount(hcount), .vcount(vcount), .xpos(xpos), .ypos(ypos),
        .address(address), .in_sprite(in_sprite)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_fsm();
        fsm_exp_t e;
        if (fq.size() == 0) begin
            n_total++;
            $error("FAIL fsm_scoreboard: observed=empty expected=entry");
        end else begin
            e = fq.pop_front();
            chk({e.tag, ".sel"},    32'(frame_sel), 32'(e.sel));
            chk({e.tag, ".busy"},   32'(busy),      32'(e.busy));
            chk({e.tag, ".ack"},    32'(throw_ack), 32'(e.ack));
            chk({e.tag, ".launch"}, 32'(launch),    32'(e.launch));
        end
    endtask

    // One frame: the tick cycle, the cycle after it (pulses must be gone), then idle gap.
    task automatic frame(input string tag, input logic req, input fsm_exp_t e);
        fsm_exp_t after;
        throw_req  = req;
        frame_tick = 1'b1;
        e.tag = tag;
        fq.push_back(e);
        @(posedge clk); #1;
        check_fsm();
        frame_tick = 1'b0;
        after = e;
        after.tag = {tag, ".after"};
        after.ack = 1'b0;
        after.launch = 1'b0;
        fq.push_back(after);
        @(posedge clk); #1;
        check_fsm();
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic fsm_exp_t mk(input logic [1:0] s, input logic b, input logic a, input logic l);
        fsm_exp_t e;
        e.tag = "";
        e.sel = s; e.busy = b; e.ack = a; e.launch = l;
        return e;
    endfunction

    // Expected outputs after the k-th tick of a throw that is accepted on tick 1.
    function automatic fsm_exp_t throw_exp(input int k);
        if (k <= 8)  return mk(2'b01, 1'b1, k == 1, 1'b0);
        if (k <= 14) return mk(2'b10, 1'b1, 1'b0, k == 9);
        if (k <= 24) return mk(2'b00, 1'b1, 1'b0, 1'b0);
        return mk(2'b00, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic ref_in(input int h, input int v, input int x, input int y);
        return (h >= x) && (h < x + 140) && (v >= y) && (v < y + 177);
    endfunction

    function automatic logic [14:0] ref_addr(input int h, input int v, input int x, input int y);
        if (!ref_in(h, v, x, y)) return 15'd0;
        return 15'((v - y) * 140 + (h - x));
    endfunction

    task automatic addr_vec(input string tag, input int h, input int v,
                            input logic [14:0] ea, input logic ei);
        adr_exp_t e, ia;
        hcount = 11'(h);
        vcount = 11'(v);
        e.tag = tag; e.addr = ea; e.ins = ei;
        aq.push_back(e);
        iq.push_back(e);
        @(posedge clk); #1;
        e = aq.pop_front();
        chk({e.tag, ".address"}, 32'(address), 32'(e.addr));
        if (iq.size() > 1) begin
            ia = iq.pop_front();
            chk({ia.tag, ".in_sprite"}, 32'(in_sprite), 32'(ia.ins));
        end
    endtask

    task automatic addr_flush();
        adr_exp_t ia;
        @(posedge clk); #1;
        while (iq.size() > 0) begin
            ia = iq.pop_front();
            chk({ia.tag, ".in_sprite"}, 32'(in_sprite), 32'(ia.ins));
        end
    endtask

    initial begin
        int h, v;
        rst = 1'b1; frame_tick = 1'b0; throw_req = 1'b0;
        hcount = '0; vcount = '0; xpos = '0; ypos = '0;
        repeat (3) @(posedge clk);
        #1;
        fq.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0));
        fq[0].tag = "reset";
        check_fsm();
        chk("reset.address",   32'(address),   32'd0);
        chk("reset.in_sprite", 32'(in_sprite), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            frame($sformatf("idle%0d", i), 1'b0, mk(2'b00, 1'b0, 1'b0, 1'b0));

        // First throw; a second request is raised during release and held.
        for (int k = 1; k <= 28; k++)
            frame($sformatf("throw_t%0d", k), (k == 1) || (k >= 11),
                  (k >= 26) ? throw_exp(k - 25) : throw_exp(k));

        // Second throw is now three ticks into WIND; abort it with reset.
        rst = 1'b1;
        throw_req = 1'b0;
        fq.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0));
        fq[0].tag = "abort";
        @(posedge clk); #1;
        check_fsm();
        rst = 1'b0;
        for (int i = 0; i < 12; i++)
            frame($sformatf("post_abort%0d", i), 1'b0, mk(2'b00, 1'b0, 1'b0, 1'b0));

        xpos = 11'd100; ypos = 11'd50;
        addr_vec("tl",      100,  50, 15'd0,     1'b1);
        addr_vec("br",      239, 226, 15'd24779, 1'b1);
        addr_vec("right",   240, 226, 15'd0,     1'b0);
        addr_vec("left",     99,  50, 15'd0,     1'b0);
        addr_vec("above",   100,  49, 15'd0,     1'b0);
        addr_vec("below",   100, 227, 15'd0,     1'b0);
        addr_vec("mid",     170, 100, 15'd7070,  1'b1);
        addr_vec("row1",    101,  51, 15'd141,   1'b1);
        for (int i = 0; i < 8; i++) begin
            h = int'($urandom_range(80, 260));
            v = int'($urandom_range(30, 240));
            addr_vec($sformatf("rnd%0d", i), h, v, ref_addr(h, v, 100, 50), ref_in(h, v, 100, 50));
        end
        addr_flush();

        xpos = 11'd2000; ypos = 11'd50;
        addr_vec("edge_max",  2047, 50, 15'd47,   1'b1);
        addr_vec("edge_row",  2047, 60, 15'd1447, 1'b1);
        addr_vec("edge_left", 1999, 60, 15'd0,    1'b0);
        addr_vec("edge_low",    10, 60, 15'd0,    1'b0);
        addr_vec("edge_x0",   2000, 50, 15'd0,    1'b1);
        addr_flush();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dog_anim_ctrl.md
Name: dog_anim_ctrl

Overview:
Sequences the dog player's throw animation and generates the pixel address for the dog sprite image ROM. The block receives a throw request from the game logic and steps the ROM frame select through idle, wind-up and release, one step per video frame. It also maps VGA counters to a sprite-relative ROM address, with an in-sprite flag aligned to the ROM's registered output. It sits between game logic and timing on one side and the dog image ROM and pixel mux on the other.

Parameters:
SPRITE_W, 140, sprite width in pixels.
SPRITE_H, 177, sprite height in pixels; SPRITE_W*SPRITE_H = 24780 ROM words.
WIND_FRAMES, 8, frames spent in wind-up (frame select 01); legal range 1..63.
RELEASE_FRAMES, 6, frames spent in release (frame select 10); legal range 1..63.
COOLDOWN_FRAMES, 10, idle-image frames after release during which requests are not accepted; legal range 0..63.

Ports:
clk  in  1  pixel clock.
rst  in  1  synchronous, active-high reset.
frame_tick  in  1  one-cycle pulse per frame, at vblank start.
throw_req  in  1  level; held by the requester until throw_ack.
throw_ack  out  1  one-cycle pulse when the request is accepted.
launch  out  1  one-cycle pulse on entry to release; spawns the projectile.
busy  out  1  high in WIND, RELEASE and COOLDOWN.
frame_sel  out  2  ROM frame select: 00 idle, 01 wind-up, 10 release; 11 is never driven.
hcount, vcount  in  11 each  VGA pixel counters.
xpos, ypos  in  11 each  sprite top-left corner on screen.
address  out  15  ROM address, registered.
in_sprite  out  1  pixel-inside-sprite flag, delayed to align with ROM rgb.

Behaviour:
- Reset values: all outputs are 0. FSM resets to IDLE, frame counter to 0, pipeline registers to 0.
- FSM states: IDLE, WIND, RELEASE, COOLDOWN.
- All state transitions and counter updates happen only in cycles where frame_tick=1, so frame_sel never changes mid-frame.
- IDLE: on frame_tick with throw_req=1, go to WIND, pulse throw_ack in that same cycle, clear the counter.
- WIND: on each frame_tick, increment the counter. When the counter reaches WIND_FRAMES-1 on a tick, go to RELEASE, pulse launch in that cycle, clear the counter.
- RELEASE: same counting against RELEASE_FRAMES-1.
  - At the end of the count, go to COOLDOWN if COOLDOWN_FRAMES>0, otherwise go to IDLE.
- COOLDOWN: same counting against COOLDOWN_FRAMES-1, then go to IDLE.
- A request present at the tick that enters IDLE is not accepted until the next tick in IDLE.
- throw_req is ignored outside IDLE. No ack is given, and the request stays pending for the requester to hold.
- frame_sel is registered, decoded from the next state: IDLE/COOLDOWN=00, WIND=01, RELEASE=10. It changes in the cycle after the tick.
- busy is registered the same way as frame_sel. throw_ack and launch are registered pulses, high exactly one cycle after the accepting tick cycle.
- Reset asserted mid-throw: the FSM aborts to IDLE the next cycle. No launch and no ack are emitted.
- Address path, stage 1 (registered):
  - Window test: in_win = (hcount>=xpos) && (hcount<xpos+SPRITE_W) && (vcount>=ypos) && (vcount<ypos+SPRITE_H).
  - Sums are computed at 12 bits, so sprites near the 2047 edge do not wrap.
  - address = (vcount-ypos)*SPRITE_W + (hcount-xpos), truncated to 15 bits when in_win; otherwise 0.
- Address path, stage 2: in_sprite = in_win delayed one more cycle. It is therefore valid together with rgb from the ROM's registered output, two cycles after hcount.
- Multiplication is by a constant. The maximum address is 24779, which fits in 15 bits.

Decomposition:
- Shared package (players_pkg): typedef enum for the FSM states; typedef for frame_sel with constants FRAME_IDLE=2'b00, FRAME_WIND=2'b01, FRAME_RELEASE=2'b10; DOG_W=140 and DOG_H=177.
- One sub-module, sprite_addr_gen. It holds the window test, address arithmetic and 2-stage in_sprite alignment, with SPRITE_W/SPRITE_H parameters, and is reusable for the cat sprite.

Test Plan:
- Reset then idle: pulse frame_tick ×5 with throw_req=0 -> frame_sel=00, busy=0, no ack or launch.
- Throw sequence: throw_req=1 before tick 1 -> ack one cycle after tick 1, frame_sel=01 for 8 ticks.
  - Then launch pulse and frame_sel=10 for 6 ticks.
  - Then 00 with busy=1 for 10 ticks, then busy=0.
- Request during busy: assert throw_req during RELEASE and hold -> no ack until the first tick in IDLE, i.e. 11 ticks after release ends (cooldown 10 plus one).
- Reset mid-WIND at tick 3 -> next cycle frame_sel=00, busy=0, and no launch ever follows.
- Address mapping with xpos=100, ypos=50:
  - hcount=100, vcount=50 -> address 0, in_sprite=1 two cycles later.
  - hcount=239, vcount=226 -> address 24779.
  - hcount=240 -> in_sprite=0, address 0.
- Edge case: xpos=2000, hcount=2047 -> in_win=1, address 47. No wrap for hcount<2000.
